// File: rtl/bfm_apbslave_pkg.sv
// Shared types and constants for the APB slave bus-functional model.
package bfm_apbslave_pkg;

  localparam int unsigned ApbAddrWidth  = 32;
  localparam int unsigned ApbDataWidth  = 32;
  localparam int unsigned WaitCyclesMax = 15;
  localparam int unsigned WaitCntWidth  = 4;
  localparam int unsigned AccCntWidth   = 16;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

endpackage

// File: rtl/bfm_apbslave_mem.sv
// Single-port word memory with synchronous read and write; read register clears on demand.
module bfm_apbslave_mem
  import bfm_apbslave_pkg::*;
#(
  parameter int unsigned AWIDTH = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    we,
  input  logic [AWIDTH-1:0]       addr,
  input  logic [ApbDataWidth-1:0] wdata,
  output logic [ApbDataWidth-1:0] rdata
);

  localparam int unsigned Depth = 1 << AWIDTH;

  // Power-up contents are zero; reset never touches the array.
  logic [ApbDataWidth-1:0] mem_q [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/bfm_apbslave.sv
// APB slave model: two-state FSM, programmable wait states, address error decode,
// master protocol checker and completed-transfer counter.
module bfm_apbslave
  import bfm_apbslave_pkg::*;
#(
  parameter int unsigned AWIDTH      = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ApbAddrWidth-1:0] PADDR,
  input  logic [ApbDataWidth-1:0] PWDATA,
  output logic [ApbDataWidth-1:0] PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    PROT_ERR,
  output logic [AccCntWidth-1:0]  ACC_COUNT
);

  localparam int unsigned WaitCfg = (WAIT_CYCLES > WaitCyclesMax) ? WaitCyclesMax : WAIT_CYCLES;
  localparam logic [WaitCntWidth-1:0] WaitInit = WaitCntWidth'(WaitCfg);

  state_e                  state_q;
  logic [WaitCntWidth-1:0] wait_cnt_q;
  logic [ApbAddrWidth-1:0] addr_q;
  logic                    write_q;
  logic [ApbDataWidth-1:0] wdata_q;
  logic                    err_q;
  logic                    pready_q;
  logic                    pslverr_q;
  logic                    prot_err_q;
  logic [AccCntWidth-1:0]  acc_count_q;

  logic                    addr_err;
  logic                    setup;
  logic                    completion;
  logic                    mismatch;
  logic                    mem_en;
  logic                    mem_we;
  logic                    mem_clr;
  logic [AWIDTH-1:0]       mem_addr;
  logic [ApbDataWidth-1:0] mem_rdata;

  always_comb begin
    addr_err   = (PADDR[1:0] != 2'b00) || ((PADDR >> (AWIDTH + 2)) != '0);
    setup      = (state_q == StIdle) && PSEL && !PENABLE;
    completion = (state_q == StAccess) && PSEL && PENABLE && pready_q;
    mismatch   = (PADDR != addr_q) || (PWRITE != write_q) || (PWDATA != wdata_q);
    // Reads fetch at the setup edge, writes commit at the completion edge: one port suffices.
    mem_we     = (state_q == StAccess);
    mem_addr   = (state_q == StAccess) ? addr_q[AWIDTH+1:2] : PADDR[AWIDTH+1:2];
    mem_en     = !PRESET && ((setup && !PWRITE && !addr_err) ||
                             (completion && write_q && !err_q));
    mem_clr    = PRESET || (setup && !PWRITE && addr_err);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (PENABLE) begin
            prot_err_q <= 1'b1;
          end else if (PSEL) begin
            state_q    <= StAccess;
            addr_q     <= PADDR;
            write_q    <= PWRITE;
            wdata_q    <= PWDATA;
            err_q      <= addr_err;
            wait_cnt_q <= WaitInit;
            pready_q   <= (WaitInit == '0);
            pslverr_q  <= (WaitInit == '0) && addr_err;
          end
        end
        StAccess: begin
          if (!PSEL) begin
            // Abort: drop the transfer without touching memory.
            prot_err_q <= 1'b1;
            state_q    <= StIdle;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
          end else begin
            if (mismatch) begin
              prot_err_q <= 1'b1;
            end
            if (completion) begin
              state_q   <= StIdle;
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
            end else if (!pready_q) begin
              // Registered PREADY tracks (counter == 0) one cycle ahead.
              wait_cnt_q <= wait_cnt_q - 4'd1;
              pready_q   <= (wait_cnt_q == 4'd1);
              pslverr_q  <= (wait_cnt_q == 4'd1) && err_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      acc_count_q <= '0;
    end else begin
      acc_count_q <= acc_count_q + AccCntWidth'(completion);
    end
  end

  bfm_apbslave_mem #(
    .AWIDTH(AWIDTH)
  ) u_mem (
    .clk  (PCLK),
    .clr  (mem_clr),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign PRDATA    = mem_rdata;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign PROT_ERR  = prot_err_q;
  assign ACC_COUNT = acc_count_q;

endmodule

// File: tb/tb_bfm_apbslave.sv
// Scoreboard bench for bfm_apbslave: three instances with 0, 3 and 5 wait states.
module tb_bfm_apbslave;

  logic        clk;
  logic        preset;
  logic [2:0]  psel;
  logic [2:0]  penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata   [3];
  logic        pready   [3];
  logic        pslverr  [3];
  logic        prot_err [3];
  logic [15:0] acc      [3];

  bfm_apbslave #(.AWIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .PROT_ERR(prot_err[0]), .ACC_COUNT(acc[0])
  );
  bfm_apbslave #(.AWIDTH(8), .WAIT_CYCLES(3)) dut1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .PROT_ERR(prot_err[1]), .ACC_COUNT(acc[1])
  );
  bfm_apbslave #(.AWIDTH(8), .WAIT_CYCLES(5)) dut2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .PROT_ERR(prot_err[2]), .ACC_COUNT(acc[2])
  );

  typedef struct {
    logic        slverr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wc [3] = '{0, 3, 5};
  logic [31:0] model_mem [3][256];
  logic [31:0] last_rd [3];
  logic [15:0] exp_acc [3];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:10] != 22'h0);
  endfunction

  task automatic clear_model_regs();
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = 32'h0;
      exp_acc[d] = 16'h0;
    end
  endtask

  // Entered and left at posedge+#1; back-to-back calls give back-to-back transfers.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   waits;
    bit   err;
    err      = addr_is_err(addr);
    e.slverr = err;
    e.rdata  = wr ? last_rd[d] : (err ? 32'h0 : model_mem[d][addr[9:2]]);
    sb_q.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!pready[d] && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    check_eq("wait_states", 32'(waits), 32'(wc[d]));
    e = sb_q.pop_front();
    check_eq("pslverr", {31'h0, pslverr[d]}, {31'h0, e.slverr});
    check_eq("prdata", prdata[d], e.rdata);
    if (!wr) last_rd[d] = e.rdata;
    else if (!err) model_mem[d][addr[9:2]] = data;
    exp_acc[d] = exp_acc[d] + 16'h1;
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    check_eq("acc_count", {16'h0, acc[d]}, {16'h0, exp_acc[d]});
    check_eq("pready_idle", {31'h0, pready[d]}, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      check_eq({tag, "_prdata"}, prdata[d], 32'h0);
      check_eq({tag, "_pready"}, {31'h0, pready[d]}, 32'h0);
      check_eq({tag, "_pslverr"}, {31'h0, pslverr[d]}, 32'h0);
      check_eq({tag, "_prot_err"}, {31'h0, prot_err[d]}, 32'h0);
      check_eq({tag, "_acc"}, {16'h0, acc[d]}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    clk = 1'b0; preset = 1'b1; psel = '0; penable = '0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) model_mem[k][i] = 32'h0;
    end
    clear_model_regs();
    repeat (3) @(posedge clk);
    #1 preset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    @(posedge clk); #1;

    // Zero-wait write then read of the same word, back to back.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 32'h0);
    check_eq("acc_two", {16'h0, acc[0]}, 32'd2);

    // Three wait states on a never-written word.
    xfer(1, 1'b0, 32'h04, 32'h0);

    // Address errors.
    xfer(0, 1'b1, 32'h2, 32'h12345678);
    xfer(0, 1'b0, 32'h0, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0);
    xfer(0, 1'b0, 32'h400, 32'h0);
    xfer(1, 1'b0, 32'h403, 32'h0);

    // Mixed traffic across all three instances.
    for (int i = 0; i < 24; i++) begin
      d = i % 3;
      a = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'b01;
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom);
    end
    xfer(1, 1'b1, 32'h3C, 32'hCAFEF00D);
    xfer(1, 1'b0, 32'h3C, 32'h0);

    // PENABLE without a setup cycle.
    check_eq("prot0_before", {31'h0, prot_err[0]}, 32'h0);
    psel[0] = 1'b1; penable[0] = 1'b1; paddr = 32'h10; pwrite = 1'b0;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    check_eq("prot0_set", {31'h0, prot_err[0]}, 32'h1);
    check_eq("prot0_acc", {16'h0, acc[0]}, {16'h0, exp_acc[0]});
    check_eq("prot0_pready", {31'h0, pready[0]}, 32'h0);

    // PSEL dropped while waiting: abort, no write.
    check_eq("prot1_before", {31'h0, prot_err[1]}, 32'h0);
    psel[1] = 1'b1; penable[1] = 1'b0; paddr = 32'h20; pwrite = 1'b1; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    check_eq("prot1_waiting", {31'h0, pready[1]}, 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    check_eq("prot1_set", {31'h0, prot_err[1]}, 32'h1);
    check_eq("prot1_acc", {16'h0, acc[1]}, {16'h0, exp_acc[1]});
    xfer(1, 1'b0, 32'h20, 32'h0);

    // Address changed during the access phase.
    psel[2] = 1'b1; penable[2] = 1'b0; paddr = 32'h30; pwrite = 1'b0;
    @(posedge clk); #1;
    penable[2] = 1'b1; paddr = 32'h34;
    @(posedge clk); #1;
    check_eq("prot2_set", {31'h0, prot_err[2]}, 32'h1);
    psel[2] = 1'b0; penable[2] = 1'b0; paddr = 32'h30;
    @(posedge clk); #1;
    check_eq("prot2_acc", {16'h0, acc[2]}, {16'h0, exp_acc[2]});

    // Reset in the middle of a five-wait-state write.
    xfer(2, 1'b1, 32'h08, 32'h11112222);
    psel[2] = 1'b1; penable[2] = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h33333333;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    preset = 1'b1; psel[0] = 1'b1; penable[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    preset = 1'b0; psel = '0; penable = '0;
    clear_model_regs();
    check_reset_state("midrst");
    @(posedge clk); #1;
    check_eq("rst_ignored_prot", {31'h0, prot_err[0]}, 32'h0);
    check_eq("rst_ignored_pready", {31'h0, pready[0]}, 32'h0);
    xfer(2, 1'b0, 32'h08, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0);

    // Counter wrap: preload near the top, then complete real transfers across it.
    force dut0.acc_count_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut0.acc_count_q;
    exp_acc[0] = 16'hFFFD;
    check_eq("wrap_preload", {16'h0, acc[0]}, 32'h0000FFFD);
    xfer(0, 1'b0, 32'h10, 32'h0);
    xfer(0, 1'b1, 32'h14, 32'h0BADCAFE);
    xfer(0, 1'b0, 32'h14, 32'h0);
    check_eq("wrap_zero", {16'h0, acc[0]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
